// File: rtl/glb_psum_accum_ctrl_if.sv
// Psum-stream and psum-buffer port bundle for glb_psum_accum_ctrl.
// master: the controller side; slave: the PE array / buffer side.
interface glb_psum_accum_ctrl_if #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10
);
  logic [DATA_BITWIDTH-1:0] psum_in;
  logic                     psum_valid;
  logic                     psum_ready;
  logic                     read_req;
  logic [ADDR_BITWIDTH-1:0] r_addr;
  logic [DATA_BITWIDTH-1:0] r_data;
  logic                     write_en;
  logic [ADDR_BITWIDTH-1:0] w_addr;
  logic [DATA_BITWIDTH-1:0] w_data;

  modport master (
    input  psum_in, psum_valid, r_data,
    output psum_ready, read_req, r_addr, write_en, w_addr, w_data
  );

  modport slave (
    output psum_in, psum_valid, r_data,
    input  psum_ready, read_req, r_addr, write_en, w_addr, w_data
  );
endinterface

// File: rtl/glb_psum_accum_ctrl.sv
// Psum global-buffer accumulation controller.
// Pass 0 overwrites a contiguous address window with incoming psums; every
// later pass reads the stored word, adds the new psum (optionally saturating)
// and writes it back. All outputs are registers loaded with the value the
// next state presents, so nothing on an input reaches an output in the same cycle.
module glb_psum_accum_ctrl #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int PASS_BITWIDTH = 8,
  parameter bit SATURATE      = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_BITWIDTH-1:0] base_addr,
  input  logic [ADDR_BITWIDTH-1:0] num_words,
  input  logic [PASS_BITWIDTH-1:0] num_passes,
  output logic                     busy,
  output logic                     done,
  glb_psum_accum_ctrl_if.master    bus
);

  localparam int DW = DATA_BITWIDTH;
  localparam int AW = ADDR_BITWIDTH;
  localparam int PW = PASS_BITWIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [AW-1:0] A_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] A_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] P_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] P_ONE   = {{(PW-1){1'b0}}, 1'b1};

  // Signed add one bit wider than the word; on overflow either clamp or keep the low bits.
  function automatic logic [DW-1:0] f_accum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_res;
    w_sum = {a[DW-1], a} + {b[DW-1], b};
    if (SATURATE && (w_sum[DW] != w_sum[DW-1])) begin
      w_res = w_sum[DW] ? SAT_MIN : SAT_MAX;
    end else begin
      w_res = w_sum[DW-1:0];
    end
    return w_res;
  endfunction

  logic [2:0]    r_state;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_num_words;
  logic [PW-1:0] r_num_passes;
  logic [AW-1:0] r_addr_cnt;
  logic [AW-1:0] r_word_cnt;
  logic [PW-1:0] r_pass_cnt;
  logic [DW-1:0] r_in;
  logic [DW-1:0] r_sum;
  logic          r_psum_ready;
  logic          r_read_req;
  logic [AW-1:0] r_rd_addr;
  logic          r_write_en;
  logic [AW-1:0] r_wr_addr;
  logic          r_busy;
  logic          r_done;

  logic          w_last_word;
  logic          w_last_pass;
  logic [DW-1:0] w_accum;

  // End-of-window / end-of-operation flags and the read-modify-write sum.
  always_comb begin
    w_last_word = (r_word_cnt == (r_num_words - A_ONE));
    w_last_pass = (r_pass_cnt == (r_num_passes - P_ONE));
    w_accum     = f_accum(bus.r_data, r_in);
  end

  // Sequencer: state, counters and registered outputs for the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_base       <= A_ZERO;
      r_num_words  <= A_ZERO;
      r_num_passes <= P_ZERO;
      r_addr_cnt   <= A_ZERO;
      r_word_cnt   <= A_ZERO;
      r_pass_cnt   <= P_ZERO;
      r_in         <= {DW{1'b0}};
      r_sum        <= {DW{1'b0}};
      r_psum_ready <= 1'b0;
      r_read_req   <= 1'b0;
      r_rd_addr    <= A_ZERO;
      r_write_en   <= 1'b0;
      r_wr_addr    <= A_ZERO;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_read_req <= 1'b0;
      r_write_en <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base       <= base_addr;
            r_num_words  <= num_words;
            r_num_passes <= num_passes;
            r_addr_cnt   <= base_addr;
            r_word_cnt   <= A_ZERO;
            r_pass_cnt   <= P_ZERO;
            r_busy       <= 1'b1;
            if ((num_words == A_ZERO) || (num_passes == P_ZERO)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_ACCEPT;
              r_psum_ready <= 1'b1;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (bus.psum_valid) begin
            r_in         <= bus.psum_in;
            r_psum_ready <= 1'b0;
            if (r_pass_cnt == P_ZERO) begin
              r_sum      <= bus.psum_in;
              r_write_en <= 1'b1;
              r_wr_addr  <= r_addr_cnt;
              r_state    <= S_WRITE;
            end else begin
              r_read_req <= 1'b1;
              r_rd_addr  <= r_addr_cnt;
              r_state    <= S_READ;
            end
          end else begin
            r_psum_ready <= 1'b1;
          end
        end
        S_READ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // r_data answers the read issued in the previous cycle.
          r_sum      <= w_accum;
          r_write_en <= 1'b1;
          r_wr_addr  <= r_addr_cnt;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          if (w_last_word) begin
            r_word_cnt <= A_ZERO;
            r_addr_cnt <= r_base;
            if (w_last_pass) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_pass_cnt   <= r_pass_cnt + P_ONE;
              r_state      <= S_ACCEPT;
              r_psum_ready <= 1'b1;
            end
          end else begin
            r_word_cnt   <= r_word_cnt + A_ONE;
            r_addr_cnt   <= r_addr_cnt + A_ONE;
            r_state      <= S_ACCEPT;
            r_psum_ready <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_psum_ready <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.psum_ready = r_psum_ready;
  assign bus.read_req   = r_read_req;
  assign bus.r_addr     = r_rd_addr;
  assign bus.write_en   = r_write_en;
  assign bus.w_addr     = r_wr_addr;
  assign bus.w_data     = r_sum;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule
